if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Parametrised next-generation instruction fetch stage with an internal synchronous instruction memory (load port) and a small prefetch FIFO that decouples fetch from decode using a valid/ready handshake. It sits between the program loader (debug/UART path) and the ID stage. It adds jump flush with in-flight read squash, halt, and a load mode, with configurable width and depth.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 8, instruction memory word-address width; DEPTH = 2**ADDR_W words.
- PC_W, 32, program counter width (byte address).
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.
- RESET_PC, 0, PC value after reset and on entering LOAD.

Ports:
- clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_we  in  1  load write enable; forces LOAD state.
- i_load_addr  in  ADDR_W  word address for load write.
- i_load_data  in  DATA_W  instruction word to write.
- i_jump  in  1  jump/branch taken.
- i_jump_addr  in  PC_W  jump target (byte address).
- i_halt  in  1  halt request.
- i_ready  in  1  decode accepts the head entry.
- o_valid  out  1  head entry valid.
- o_instr  out  DATA_W  head instruction.
- o_pc  out  PC_W  byte PC of head instruction.
- o_state  out  2  current FSM state (debug).

Behaviour:
- Reset (async): FSM=IDLE, PC=RESET_PC, FIFO empty, in-flight cleared. Outputs: o_valid=0, o_instr=0, o_pc=0, o_state=IDLE. Memory contents are not reset.
- Memory: synchronous write when i_we; synchronous read, 1-cycle latency; read index = PC[ADDR_W+1:2]. Addresses beyond DEPTH alias by truncation.
- FSM states:
  - IDLE -> LOAD on i_we; IDLE -> RUN on !i_we && !i_halt.
  - Any state -> LOAD on i_we. Entry into LOAD flushes the FIFO, squashes the in-flight read, and sets PC=RESET_PC.
  - LOAD -> RUN on !i_we && !i_halt; LOAD -> HALT on !i_we && i_halt.
  - RUN -> HALT on i_halt; HALT -> RUN on !i_halt.
- Issue: in RUN only, when (fifo_count + inflight) < FIFO_DEPTH and !i_jump. Issue reads the memory at PC, tags the read with PC, then sets PC = PC + 4 (wraps modulo 2**PC_W). At most one issue per cycle, so a sustained rate of 1 instruction per cycle when decode is always ready.
- Response: one cycle after issue, the {instr, pc} pair is pushed unless squashed.
- Latency: first o_valid is asserted 2 cycles after the first RUN cycle.
- Output: o_valid = !empty && state==RUN. o_instr and o_pc show the FIFO head whenever the FIFO is non-empty, and hold their last values otherwise. A pop occurs on o_valid && i_ready. o_instr and o_pc must stay stable while o_valid && !i_ready.
- Push and pop in the same cycle are legal at any occupancy. The credit rule guarantees the FIFO never overflows.
- Jump (RUN or HALT): in the jump cycle there is no issue, the FIFO is flushed next edge, the in-flight read is squashed, and PC = i_jump_addr. A pop in the same cycle is ignored because the flush wins. Jump together with halt: the jump is applied and the FSM enters HALT. Jump in IDLE or LOAD is ignored.
- HALT: no issue and no pop (o_valid=0). The in-flight response is still pushed, and FIFO contents are retained for the return to RUN.
- Reset mid-operation discards everything immediately, asynchronously.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output o_misalign (1 bit, reset 0).
  - A jump with i_jump_addr[1:0] != 0 is ignored: no flush, no PC change.
  - o_misalign is set and remains sticky until reset or LOAD entry.
- Undefined:
  - Port absent.
  - Target bits [1:0] are used as-is; fetch index still uses PC[ADDR_W+1:2].

Decomposition:
- Package if_pkg: FSM state localparams (IDLE=0, LOAD=1, RUN=2, HALT=3), PC_INC=4, NOP instruction constant.
- Sub-module if_prefetch_fifo: synchronous FIFO of {pc, instr} with push, pop, a flush that takes priority over both, count, empty and full.
- Memory: existing single-port RAM style, written inline or instantiated.

Test Plan:
- Load: write mem[0..3]=0x11,0x22,0x33,0x44, drop i_we, i_ready=1 -> first o_valid 2 cycles after RUN; o_instr 0x11..0x44 on consecutive cycles; o_pc 0,4,8,12.
- Backpressure: i_ready=0 for 10 cycles -> FIFO fills to FIFO_DEPTH; issue stops; o_instr is held at 0x11; release -> no instruction lost or duplicated.
- Jump flush: jump to 0x8 while FIFO holds 3 entries and a read is in flight -> nothing from the old stream appears; next output is o_pc=8, o_instr=0x33.
- Halt: assert i_halt for 5 cycles mid-stream -> o_valid=0, PC frozen; release -> stream resumes at the exact next PC.
- Wrap and reset: PC_W=ADDR_W+2, run past the last word -> o_pc wraps to 0 and mem[0] is refetched. Assert i_rst mid-stream -> o_valid=0 and o_state=IDLE with no clock edge.
- Misalign (macro on): jump to 0x6 -> o_misalign=1, stream unchanged; jump to 0x4 -> flush with o_misalign still 1.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants for the instruction fetch stage: FSM encodings, PC step and NOP word.
package if_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam int PC_INC = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush overrides push and pop in the same cycle.
module if_prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: load port, sync instruction RAM, credit-based prefetch into a FIFO.
// Optional IF_ALIGN_CHECK_EN: ignore misaligned jump targets and raise sticky o_misalign.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 8,
  parameter int              PC_W       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_jump,
  input  logic [PC_W-1:0]   i_jump_addr,
  input  logic              i_halt,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [PC_W-1:0]   o_pc,
`ifdef IF_ALIGN_CHECK_EN
  output logic              o_misalign,
`endif
  output logic [1:0]        o_state
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = $clog2(FIFO_DEPTH);

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [PC_W-1:0]       pc;
  logic [PC_W-1:0]       tag_pc;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rdata;
  logic                  inflight;
  logic [CW:0]           fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [PC_W+DATA_W-1:0] fifo_dout;
  logic [PC_W-1:0]       hold_pc;
  logic [DATA_W-1:0]     hold_instr;
  logic [CW+1:0]         occupancy;
  logic                  jump_ok;
  logic                  jump_take;
  logic                  issue;
  logic                  flush;
  logic                  pop;

  assign jump_ok = i_jump && (state == ST_RUN || state == ST_HALT);
`ifdef IF_ALIGN_CHECK_EN
  assign jump_take = jump_ok && (i_jump_addr[1:0] == 2'b00);
`else
  assign jump_take = jump_ok;
`endif

  // Credits: queued entries plus the read in flight must leave room in the FIFO.
  assign occupancy = {1'b0, fifo_count} + {{(CW+1){1'b0}}, inflight};
  assign issue     = (state == ST_RUN) && !i_we && !jump_take && !fifo_full &&
                     (occupancy < (CW+2)'(FIFO_DEPTH));
  assign flush     = i_we || jump_take;
  assign o_valid   = !fifo_empty && (state == ST_RUN);
  assign pop       = o_valid && i_ready;
  assign o_state   = state;

  always_comb begin
    state_nx = state;
    if (i_we) begin
      state_nx = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE: if (!i_halt) state_nx = ST_RUN;
        ST_LOAD: state_nx = i_halt ? ST_HALT : ST_RUN;
        ST_RUN:  if (i_halt) state_nx = ST_HALT;
        default: if (!i_halt) state_nx = ST_RUN;
      endcase
    end
  end

  // A flush cycle never issues, so clearing inflight here also squashes the pending response.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (issue) tag_pc <= pc;
      if (i_we)           pc <= RESET_PC;
      else if (jump_take) pc <= i_jump_addr;
      else if (issue)     pc <= pc + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (i_we)  mem[i_load_addr] <= i_load_data;
    if (issue) rdata <= mem[pc[ADDR_W+1:2]];
  end

  if_prefetch_fifo #(
    .W     (PC_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (inflight),
    .pop   (pop),
    .flush (flush),
    .din   ({tag_pc, rdata}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Outputs keep showing the last head after the FIFO drains.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (!fifo_empty) begin
      {hold_pc, hold_instr} <= fifo_dout;
    end
  end

  assign {o_pc, o_instr} = fifo_empty ? {hold_pc, hold_instr} : fifo_dout;

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                                       o_misalign <= 1'b0;
    else if (i_we)                                   o_misalign <= 1'b0;
    else if (jump_ok && (i_jump_addr[1:0] != 2'b00)) o_misalign <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: stream-level reference model plus directed latency/flush/halt/wrap/reset cases.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int PC_W       = 6;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_we;
  logic [ADDR_W-1:0] i_load_addr;
  logic [DATA_W-1:0] i_load_data;
  logic              i_jump;
  logic [PC_W-1:0]   i_jump_addr;
  logic              i_halt;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_instr;
  logic [PC_W-1:0]   o_pc;
  logic [1:0]        o_state;
`ifdef IF_ALIGN_CHECK_EN
  logic              o_misalign;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem_m [16];
  logic [PC_W-1:0]   exp_pc  = '0;
  logic [1:0]        m_state = ST_IDLE;
  logic [DATA_W-1:0] exp_q[$];

  if_fetch_unit #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .PC_W       (PC_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_we        (i_we),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .i_jump      (i_jump),
    .i_jump_addr (i_jump_addr),
    .i_halt      (i_halt),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
`ifdef IF_ALIGN_CHECK_EN
    .o_misalign  (o_misalign),
`endif
    .o_state     (o_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reload_word0();
    i_we        = 1'b1;
    i_load_addr = '0;
    i_load_data = 32'h11;
    tick();
    i_we = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i < 8) return DATA_W'(32'h11 * (i + 1));
    return NOP | (DATA_W'(i) << 20);
  endfunction

  // Reference model: the accepted stream is consecutive words from the expected PC.
  always @(negedge clk) begin
    logic jok;
    if (i_rst) begin
      check("rst_valid", {63'd0, o_valid}, 64'd0);
      m_state = ST_IDLE;
      exp_pc  = '0;
    end else begin
      check("state", {62'd0, o_state}, {62'd0, m_state});
      if (m_state != ST_RUN) check("valid_off", {63'd0, o_valid}, 64'd0);
      if (o_valid) begin
        check("head_pc", {58'd0, o_pc}, {58'd0, exp_pc});
        check("head_instr", {32'd0, o_instr}, {32'd0, mem_m[exp_pc[5:2]]});
      end
      jok = i_jump && (m_state == ST_RUN || m_state == ST_HALT);
`ifdef IF_ALIGN_CHECK_EN
      jok = jok && (i_jump_addr[1:0] == 2'b00);
`endif
      if (i_we) begin
        mem_m[i_load_addr] = i_load_data;
        exp_pc = '0;
      end else if (jok) begin
        exp_pc = i_jump_addr;
      end else if (o_valid && i_ready) begin
        exp_pc = exp_pc + 6'd4;
      end
      if (i_we) m_state = ST_LOAD;
      else if (m_state == ST_IDLE) m_state = i_halt ? ST_IDLE : ST_RUN;
      else if (m_state == ST_LOAD) m_state = i_halt ? ST_HALT : ST_RUN;
      else if (m_state == ST_RUN)  m_state = i_halt ? ST_HALT : ST_RUN;
      else                         m_state = i_halt ? ST_HALT : ST_RUN;
    end
  end

  initial begin
    logic [DATA_W-1:0] w;
    i_rst = 1'b1; i_we = 1'b0; i_load_addr = '0; i_load_data = '0;
    i_jump = 1'b0; i_jump_addr = '0; i_halt = 1'b1; i_ready = 1'b0;
    #2;
    check("reset_valid", {63'd0, o_valid}, 64'd0);
    check("reset_instr", {32'd0, o_instr}, 64'd0);
    check("reset_pc",    {58'd0, o_pc},    64'd0);
    check("reset_state", {62'd0, o_state}, 64'd0);
    tick(); tick();
    i_rst = 1'b0;
    tick();
    check("idle_hold", {62'd0, o_state}, {62'd0, ST_IDLE});

    // Load all words; first four are 0x11..0x44.
    i_halt  = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_we = 1'b1; i_load_addr = ADDR_W'(i); i_load_data = init_word(i);
      tick();
    end
    i_we = 1'b0;
    exp_q = {32'h11, 32'h22, 32'h33, 32'h44};
    tick();
    check("lat_state_run", {62'd0, o_state}, {62'd0, ST_RUN});
    check("lat_valid_c0", {63'd0, o_valid}, 64'd0);
    tick();
    check("lat_valid_c1", {63'd0, o_valid}, 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      check("load_valid", {63'd0, o_valid}, 64'd1);
      check("load_instr", {32'd0, o_instr}, {32'd0, w});
      check("load_pc", {58'd0, o_pc}, 64'(4 * k));
      tick();
    end

    // Backpressure: decode stalls, FIFO fills, head must hold.
    i_ready = 1'b0;
    reload_word0();
    for (int k = 0; k < 12; k++) tick();
    check("bp_valid", {63'd0, o_valid}, 64'd1);
    check("bp_instr_held", {32'd0, o_instr}, 64'h11);
    check("bp_pc_held", {58'd0, o_pc}, 64'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_release_valid", {63'd0, o_valid}, 64'd1);
      check("bp_release_pc", {58'd0, o_pc}, 64'(4 * k));
      tick();
    end

    // Jump with three queued entries and one read in flight.
    i_ready = 1'b0;
    reload_word0();
    for (int k = 0; k < 5; k++) tick();
    check("jmp_pre_valid", {63'd0, o_valid}, 64'd1);
    check("jmp_pre_pc", {58'd0, o_pc}, 64'd0);
    i_jump = 1'b1; i_jump_addr = 6'h08;
    tick();
    i_jump = 1'b0;
    check("jmp_flushed_c0", {63'd0, o_valid}, 64'd0);
    tick();
    check("jmp_flushed_c1", {63'd0, o_valid}, 64'd0);
    tick();
    check("jmp_valid", {63'd0, o_valid}, 64'd1);
    check("jmp_pc", {58'd0, o_pc}, 64'd8);
    check("jmp_instr", {32'd0, o_instr}, 64'h33);
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Halt mid-stream for five cycles.
    check("halt_pre_pc", {58'd0, o_pc}, 64'd24);
    i_halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("halt_state", {62'd0, o_state}, {62'd0, ST_HALT});
      check("halt_valid", {63'd0, o_valid}, 64'd0);
    end
    i_halt = 1'b0;
    tick();
    check("halt_resume_valid", {63'd0, o_valid}, 64'd1);
    check("halt_resume_pc", {58'd0, o_pc}, 64'd28);

    // PC wraps from the last word back to word 0.
    for (int k = 0; k < 40 && !(o_valid && o_pc == 6'd60); k++) tick();
    check("wrap_reach_60", {63'd0, (o_valid && o_pc == 6'd60)}, 64'd1);
    tick();
    for (int k = 0; k < 5 && !o_valid; k++) tick();
    check("wrap_pc", {58'd0, o_pc}, 64'd0);
    check("wrap_instr", {32'd0, o_instr}, 64'h11);

    // Asynchronous reset mid-stream, checked before any clock edge.
    tick();
    i_rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, o_valid}, 64'd0);
    check("arst_state", {62'd0, o_state}, {62'd0, ST_IDLE});
    check("arst_pc", {58'd0, o_pc}, 64'd0);
    check("arst_instr", {32'd0, o_instr}, 64'd0);
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < 10 && !o_valid; k++) tick();
    check("post_rst_pc", {58'd0, o_pc}, 64'd0);
    check("post_rst_instr", {32'd0, o_instr}, 64'h11);

`ifdef IF_ALIGN_CHECK_EN
    check("mis_init", {63'd0, o_misalign}, 64'd0);
    i_jump = 1'b1; i_jump_addr = 6'h06;
    tick();
    i_jump = 1'b0;
    check("mis_set", {63'd0, o_misalign}, 64'd1);
    for (int k = 0; k < 3; k++) tick();
    i_jump = 1'b1; i_jump_addr = 6'h04;
    tick();
    i_jump = 1'b0;
    check("mis_sticky", {63'd0, o_misalign}, 64'd1);
    for (int k = 0; k < 10 && !o_valid; k++) tick();
    check("mis_jump_pc", {58'd0, o_pc}, 64'd4);
`endif

    for (int k = 0; k < 6; k++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
